i2c_bus_conditioner: RTL and testbench

- Front-end stage directly upstream of i2c_target.
- Synchronises raw SCL/SDA pad inputs to clk_i and removes glitches.
- Emits clean levels, single-cycle SCL edge strobes, START/STOP strobes and a bus-busy flag, so i2c_target's state machine runs on qualified events only.
- SDA output drive stays in i2c_target; this block only observes the pad.

---
 rtl/pca_i2c_pkg.sv | 29 ++
 rtl/i2c_glitch_filter.sv | 51 +++++
 rtl/i2c_bus_conditioner.sv | 121 ++++++++++++
 tb/tb_i2c_bus_conditioner.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pca_i2c_pkg.sv
// Shared I2C constants and event decode used by the bus conditioner and its neighbours.
package pca_i2c_pkg;

   localparam logic        I2C_IDLE_LEVEL     = 1'b1;
   localparam int unsigned SYNC_STAGES_DEF    = 2;
   localparam int unsigned FILTER_CYCLES_DEF  = 4;
   localparam int unsigned TIMEOUT_CYCLES_DEF = 25000;

   typedef struct packed {
      logic scl_rise;
      logic scl_fall;
      logic start;
      logic stop;
   } i2c_evt_t;

   // START/STOP only count when SCL was high on both sides of the SDA edge.
   function automatic i2c_evt_t detect_events(input logic scl, input logic scl_prev,
                                              input logic sda, input logic sda_prev);
      i2c_evt_t evt;
      logic     scl_stable_hi;
      scl_stable_hi = scl & scl_prev;
      evt.scl_rise  = scl & ~scl_prev;
      evt.scl_fall  = ~scl & scl_prev;
      evt.start     = scl_stable_hi & sda_prev & ~sda;
      evt.stop      = scl_stable_hi & ~sda_prev & sda;
      return evt;
   endfunction

endpackage

// File: rtl/i2c_glitch_filter.sv
// One I2C line: flop-only synchroniser followed by a stable-count glitch filter.
module i2c_glitch_filter
   import pca_i2c_pkg::*;
#(
   parameter int unsigned SYNC_STAGES   = SYNC_STAGES_DEF,
   parameter int unsigned FILTER_CYCLES = FILTER_CYCLES_DEF
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic line_i,
   output logic line_o
);

   localparam int unsigned          CNT_W    = $clog2(FILTER_CYCLES + 1);
   localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   filt_q, filt_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;

   // Shift the pad into the chain and count how long the synced level disagrees.
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], line_i};
      filt_d = filt_q;
      cnt_d  = {CNT_W{1'b0}};
      if (sync_q[SYNC_STAGES-1] == filt_q) begin
         cnt_d = {CNT_W{1'b0}};
      end else if (cnt_q == CNT_LAST) begin
         filt_d = ~filt_q;
         cnt_d  = {CNT_W{1'b0}};
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // State registers; everything resets to an idle (high) bus.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= {SYNC_STAGES{I2C_IDLE_LEVEL}};
         filt_q <= I2C_IDLE_LEVEL;
         cnt_q  <= {CNT_W{1'b0}};
      end else begin
         sync_q <= sync_d;
         filt_q <= filt_d;
         cnt_q  <= cnt_d;
      end
   end

   assign line_o = filt_q;

endmodule

// File: rtl/i2c_bus_conditioner.sv
// Cleans raw SCL/SDA and emits edge, START/STOP, busy and timeout qualifiers.
// Optional SCL-low bus timeout is compiled in with I2C_BUS_TIMEOUT_EN.
module i2c_bus_conditioner
   import pca_i2c_pkg::*;
#(
   parameter int unsigned SYNC_STAGES    = SYNC_STAGES_DEF,
   parameter int unsigned FILTER_CYCLES  = FILTER_CYCLES_DEF,
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic scl_i,
   input  logic sda_i,
   output logic scl_o,
   output logic sda_o,
   output logic scl_rise_o,
   output logic scl_fall_o,
   output logic start_o,
   output logic stop_o,
   output logic busy_o,
   output logic timeout_o
);

   logic     scl_s, sda_s;
   logic     scl_prev_q, sda_prev_q;
   i2c_evt_t evt_q, evt_d;
   logic     busy_q, busy_d;
   logic     timeout_q, timeout_s;

   i2c_glitch_filter #(
      .SYNC_STAGES   (SYNC_STAGES),
      .FILTER_CYCLES (FILTER_CYCLES)
   ) u_scl_filter (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .line_i (scl_i),
      .line_o (scl_s)
   );

   i2c_glitch_filter #(
      .SYNC_STAGES   (SYNC_STAGES),
      .FILTER_CYCLES (FILTER_CYCLES)
   ) u_sda_filter (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .line_i (sda_i),
      .line_o (sda_s)
   );

`ifdef I2C_BUS_TIMEOUT_EN
   localparam int unsigned      TO_W   = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TO_W-1:0]  TO_MAX = TO_W'(TIMEOUT_CYCLES);

   logic [TO_W-1:0] to_cnt_q, to_cnt_d;

   // Count SCL-low cycles while busy; saturate so a stuck bus pulses only once.
   always_comb begin
      to_cnt_d = to_cnt_q;
      if (!busy_q || scl_s) begin
         to_cnt_d = {TO_W{1'b0}};
      end else if (to_cnt_q == TO_MAX) begin
         to_cnt_d = to_cnt_q;
      end else begin
         to_cnt_d = to_cnt_q + TO_W'(1);
      end
      timeout_s = (to_cnt_d == TO_MAX) && (to_cnt_q != TO_MAX);
   end

   // Timeout counter register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         to_cnt_q <= {TO_W{1'b0}};
      end else begin
         to_cnt_q <= to_cnt_d;
      end
   end
`else
   // The parameter stays referenced so both builds share one interface.
   assign timeout_s = 1'b0 & (TIMEOUT_CYCLES == 32'd0);
`endif

   // Decode events from the filtered levels against their previous-cycle copies.
   always_comb begin
      evt_d  = detect_events(scl_s, scl_prev_q, sda_s, sda_prev_q);
      busy_d = busy_q;
      if (evt_d.start) begin
         busy_d = 1'b1;
      end else if (evt_d.stop || timeout_s) begin
         busy_d = 1'b0;
      end else begin
         busy_d = busy_q;
      end
   end

   // Registered strobes, busy flag and previous-level copies.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         scl_prev_q <= I2C_IDLE_LEVEL;
         sda_prev_q <= I2C_IDLE_LEVEL;
         evt_q      <= 4'b0000;
         busy_q     <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         scl_prev_q <= scl_s;
         sda_prev_q <= sda_s;
         evt_q      <= evt_d;
         busy_q     <= busy_d;
         timeout_q  <= timeout_s;
      end
   end

   assign scl_o      = scl_s;
   assign sda_o      = sda_s;
   assign scl_rise_o = evt_q.scl_rise;
   assign scl_fall_o = evt_q.scl_fall;
   assign start_o    = evt_q.start;
   assign stop_o     = evt_q.stop;
   assign busy_o     = busy_q;
   assign timeout_o  = timeout_q;

endmodule

// File: tb/tb_i2c_bus_conditioner.sv
// Scoreboard bench for i2c_bus_conditioner; expects the timeout pulse only when
// I2C_BUS_TIMEOUT_EN is defined.
module tb_i2c_bus_conditioner;

   localparam int TO      = 100;
   localparam int LAT     = 7;   // pad change to strobe: 2 sync + 4 filter + 1 register
   localparam int EV_RISE = 1;
   localparam int EV_FALL = 2;
   localparam int EV_START = 3;
   localparam int EV_STOP = 4;
   localparam int EV_TOUT = 5;

   logic clk_i = 1'b0;
   logic rst_ni, scl_i, sda_i;
   logic scl_o, sda_o, scl_rise_o, scl_fall_o, start_o, stop_o, busy_o, timeout_o;

   typedef struct {
      int   kind;
      int   at;
      logic busy;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc = 0;
   int   last_k = 0;
   logic ps, pd, busy_m;

   i2c_bus_conditioner #(
      .SYNC_STAGES    (2),
      .FILTER_CYCLES  (4),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .scl_i      (scl_i),
      .sda_i      (sda_i),
      .scl_o      (scl_o),
      .sda_o      (sda_o),
      .scl_rise_o (scl_rise_o),
      .scl_fall_o (scl_fall_o),
      .start_o    (start_o),
      .stop_o     (stop_o),
      .busy_o     (busy_o),
      .timeout_o  (timeout_o)
   );

   always #5 clk_i = ~clk_i;

   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic sb_push(input int kind, input int at, input logic b);
      exp_t e;
      e.kind = kind;
      e.at   = at;
      e.busy = b;
      sb_q.push_back(e);
   endtask

   // Pad-level intent: what the bus change should mean once filtered.
   task automatic expect_change(input logic s, input logic d);
      if (s != ps) begin
         sb_push(s ? EV_RISE : EV_FALL, cyc + LAT, busy_m);
      end else if (ps && (d != pd)) begin
         busy_m = !d;
         sb_push(d ? EV_STOP : EV_START, cyc + LAT, busy_m);
      end
      ps = s;
      pd = d;
   endtask

   task automatic pad(input logic s, input logic d, input int hold);
      @(negedge clk_i);
      last_k = cyc;
      expect_change(s, d);
      scl_i = s;
      sda_i = d;
      repeat (hold) @(negedge clk_i);
   endtask

   task automatic send_bits(input logic [8:0] bits);
      for (int i = 8; i >= 0; i--) begin
         pad(1'b0, pd, 8);
         pad(1'b0, bits[i], 8);
         pad(1'b1, bits[i], 8);
      end
   endtask

   task automatic sb_check(input int kind);
      exp_t e;
      if (sb_q.size() == 0) begin
         check_eq("unexpected_event", kind, 0);
      end else begin
         e = sb_q.pop_front();
         check_eq("event_kind", kind, e.kind);
         check_eq("event_cycle", cyc, e.at);
         check_eq("busy_at_event", busy_o, e.busy);
      end
   endtask

   always @(negedge clk_i) begin
      if (rst_ni === 1'b1) begin
         if (scl_rise_o) sb_check(EV_RISE);
         if (scl_fall_o) sb_check(EV_FALL);
         if (start_o)    sb_check(EV_START);
         if (stop_o)     sb_check(EV_STOP);
         if (timeout_o)  sb_check(EV_TOUT);
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_ni = 1'b0;
      scl_i  = 1'b0;
      sda_i  = 1'b0;
      ps     = 1'b1;
      pd     = 1'b1;
      busy_m = 1'b0;

      repeat (3) @(negedge clk_i);
      check_eq("rst_scl", scl_o, 1);
      check_eq("rst_sda", sda_o, 1);
      check_eq("rst_busy", busy_o, 0);
      check_eq("rst_strobes", {scl_rise_o, scl_fall_o, start_o, stop_o, timeout_o}, 0);

      // Release with both pads low: only an SCL fall, 6 cycles later.
      @(negedge clk_i);
      expect_change(1'b0, 1'b0);
      rst_ni = 1'b1;
      repeat (5) @(negedge clk_i);
      check_eq("lat5_scl", scl_o, 1);
      @(negedge clk_i);
      check_eq("lat6_scl", scl_o, 0);
      check_eq("lat6_sda", sda_o, 0);
      repeat (4) @(negedge clk_i);

      // Back to idle; SDA rising with SCL high is a STOP while not busy.
      pad(1'b1, 1'b0, 10);
      pad(1'b1, 1'b1, 10);
      check_eq("stop_idle_busy", busy_o, 0);

      // 3-cycle glitch is swallowed.
      @(negedge clk_i);
      sda_i = 1'b0;
      repeat (3) @(negedge clk_i);
      sda_i = 1'b1;
      repeat (12) @(negedge clk_i);
      check_eq("glitch3_sda", sda_o, 1);
      check_eq("glitch3_busy", busy_o, 0);

      // 4-cycle pulse passes: START then STOP.
      @(negedge clk_i);
      expect_change(1'b1, 1'b0);
      sda_i = 1'b0;
      repeat (4) @(negedge clk_i);
      expect_change(1'b1, 1'b1);
      sda_i = 1'b1;
      repeat (4) @(negedge clk_i);
      check_eq("pulse4_sda", sda_o, 0);
      check_eq("pulse4_busy", busy_o, 1);
      repeat (10) @(negedge clk_i);

      // Byte framing.
      pad(1'b1, 1'b0, 10);
      send_bits(9'b1010_0101_0);
      pad(1'b0, pd, 8);
      pad(1'b0, 1'b0, 8);
      pad(1'b1, 1'b0, 8);
      pad(1'b1, 1'b1, 10);

      // Repeated START.
      pad(1'b1, 1'b0, 10);
      send_bits(9'b0011_1100_1);
      pad(1'b0, pd, 8);
      pad(1'b0, 1'b1, 8);
      pad(1'b1, 1'b1, 8);
      pad(1'b1, 1'b0, 10);
      check_eq("rstart_busy", busy_o, 1);
      pad(1'b0, 1'b0, 8);
      pad(1'b1, 1'b0, 8);
      pad(1'b1, 1'b1, 10);

      // Simultaneous SCL/SDA changes: only SCL edges.
      pad(1'b0, 1'b0, 10);
      pad(1'b1, 1'b1, 10);
      check_eq("simul_busy", busy_o, 0);

      // Reset in the middle of a transaction.
      pad(1'b1, 1'b0, 10);
      @(negedge clk_i);
      rst_ni = 1'b0;
      scl_i  = 1'b1;
      sda_i  = 1'b1;
      ps     = 1'b1;
      pd     = 1'b1;
      busy_m = 1'b0;
      @(negedge clk_i);
      check_eq("midrst_busy", busy_o, 0);
      check_eq("midrst_sda", sda_o, 1);
      repeat (2) @(negedge clk_i);
      rst_ni = 1'b1;
      repeat (12) @(negedge clk_i);

      // SCL held low while busy.
      pad(1'b1, 1'b0, 10);
      pad(1'b0, 1'b0, 0);
`ifdef I2C_BUS_TIMEOUT_EN
      sb_push(EV_TOUT, last_k + 6 + TO, 1'b0);
      busy_m = 1'b0;
`endif
      repeat (200) @(negedge clk_i);
`ifdef I2C_BUS_TIMEOUT_EN
      check_eq("timeout_busy", busy_o, 0);
`else
      check_eq("timeout_busy", busy_o, 1);
`endif
      check_eq("timeout_low", timeout_o, 0);
      pad(1'b1, 1'b0, 10);
      pad(1'b1, 1'b1, 10);

      // Normal START/STOP afterwards.
      pad(1'b1, 1'b0, 10);
      check_eq("post_start_busy", busy_o, 1);
      pad(1'b1, 1'b1, 10);

      repeat (20) @(negedge clk_i);
      check_eq("scoreboard_drain", sb_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
